// File: rtl/my_riscv_core_matrix_bus_decoder_pkg.sv
// ---------------------------------------------------------------------------
// my_riscv_core_matrix_bus_decoder_pkg
// Definitions shared by the matrix-bus decoder and its default slave:
//   - AHB HRESP encodings
//   - AHB HTRANS encodings
//   - slave count and the data-phase index of the internal default slave
//   - helper to turn the one-hot data-phase select into a slave index
// ---------------------------------------------------------------------------
package my_riscv_core_matrix_bus_decoder_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY  = 2'b00,
        RESP_ERROR = 2'b01,
        RESP_RETRY = 2'b10,
        RESP_SPLIT = 2'b11
    } hresp_e;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } htrans_e;

    localparam int NUM_SLAVES  = 4;
    localparam int DEFAULT_SLV = 4;   // dsel bit / ERRSLV code of the default slave

    // One-hot (5-bit) data-phase select to slave index; 0 if no bit is set.
    function automatic logic [2:0] onehot_to_index(input logic [4:0] onehot);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (onehot[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/my_riscv_core_matrix_bus_decoder_default_slave.sv
// ---------------------------------------------------------------------------
// my_riscv_core_matrix_bus_default_slave
// Internal default slave of the matrix-bus decoder. It owns every address
// that misses all slave regions. An active transfer (NONSEQ/SEQ) accepted
// while selected gets the two-cycle AHB ERROR response; IDLE/BUSY get a
// zero-wait OKAY.
//
// Ports:
//   HCLK       in  clock
//   HRESETn    in  asynchronous active-low reset
//   hsel       in  address decoded to no slave region
//   active     in  current transfer is NONSEQ or SEQ
//   hready     in  bus-wide HREADY (transfer accepted on this edge)
//   hreadyout  out ready contribution of the default slave (registered)
//   hresp      out response of the default slave (registered)
// ---------------------------------------------------------------------------
module my_riscv_core_matrix_bus_default_slave
    import my_riscv_core_matrix_bus_decoder_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       hsel,
    input  logic       active,
    input  logic       hready,
    output logic       hreadyout,
    output logic [1:0] hresp
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ERR1 = 2'b01,
        ST_ERR2 = 2'b10
    } state_e;

    state_e state;

    // Outputs are registered alongside the state so that the response seen
    // in each data-phase cycle comes straight from flops.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            hreadyout <= 1'b1;
            hresp     <= RESP_OKAY;
        end else begin
            case (state)
                ST_ERR1: begin
                    // Second ERROR cycle: release the bus, keep ERROR.
                    state     <= ST_ERR2;
                    hreadyout <= 1'b1;
                    hresp     <= RESP_ERROR;
                end
                default: begin
                    // Idle or last ERROR cycle: a new address phase may be
                    // accepted here (back-to-back errors are possible).
                    if (hready) begin
                        if (hsel && active) begin
                            state     <= ST_ERR1;
                            hreadyout <= 1'b0;
                            hresp     <= RESP_ERROR;
                        end else begin
                            state     <= ST_IDLE;
                            hreadyout <= 1'b1;
                            hresp     <= RESP_OKAY;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/my_riscv_core_matrix_bus_decoder.sv
// ---------------------------------------------------------------------------
// my_riscv_core_matrix_bus_decoder
// AHB address decoder and response multiplexer for four slaves plus an
// internal default slave, with capture of the first erroring transfer.
//
// Ports:
//   HCLK, HRESETn  clock, asynchronous active-low reset
//   HADDR[31:0]    master address          HTRANS[1:0] master transfer type
//   HSEL_S[3:0]    per-slave select (combinational from HADDR)
//   HREADYOUT_S[3:0], HRESP_S[7:0], HRDATA_S[127:0]  slave returns, slave n
//                  at bit n / [2n+1:2n] / [32n+31:32n]
//   HREADY, HRESP, HRDATA  muxed by the data-phase select
//   ERRCLR         synchronous clear of the error capture
//   ERRVALID, ERRADDR, ERRSLV  captured error (ERRSLV 0-3 slave, 4 default)
// ---------------------------------------------------------------------------
module my_riscv_core_matrix_bus_decoder
    import my_riscv_core_matrix_bus_decoder_pkg::*;
#(
    parameter logic [31:0] BASE0 = 32'h0000_0000,
    parameter logic [31:0] MASK0 = 32'hFFFF_0000,
    parameter logic [31:0] BASE1 = 32'h2000_0000,
    parameter logic [31:0] MASK1 = 32'hFFFF_0000,
    parameter logic [31:0] BASE2 = 32'h4000_0000,
    parameter logic [31:0] MASK2 = 32'hF000_0000,
    parameter logic [31:0] BASE3 = 32'h6000_0000,
    parameter logic [31:0] MASK3 = 32'hF000_0000
) (
    input  logic         HCLK,
    input  logic         HRESETn,
    input  logic [31:0]  HADDR,
    input  logic [1:0]   HTRANS,
    output logic [3:0]   HSEL_S,
    input  logic [3:0]   HREADYOUT_S,
    input  logic [7:0]   HRESP_S,
    input  logic [127:0] HRDATA_S,
    output logic         HREADY,
    output logic [1:0]   HRESP,
    output logic [31:0]  HRDATA,
    input  logic         ERRCLR,
    output logic         ERRVALID,
    output logic [31:0]  ERRADDR,
    output logic [2:0]   ERRSLV
);

    logic [3:0]  region_hit;
    logic [3:0]  sel;
    logic        no_match;
    logic        active;
    logic [4:0]  dsel;
    logic [31:0] haddr_dp;
    logic        def_ready;
    logic [1:0]  def_resp;
    logic        capture;
    logic        err_valid;
    logic [31:0] err_addr;
    logic [2:0]  err_slv;

    // ---------------- address-phase decode (HADDR only) ----------------
    always_comb begin
        region_hit[0] = (HADDR & MASK0) == BASE0;
        region_hit[1] = (HADDR & MASK1) == BASE1;
        region_hit[2] = (HADDR & MASK2) == BASE2;
        region_hit[3] = (HADDR & MASK3) == BASE3;
    end

    // Lowest index wins so overlapping regions still yield a one-hot select.
    always_comb begin
        sel = 4'b0000;
        if (region_hit[0]) begin
            sel[0] = 1'b1;
        end else if (region_hit[1]) begin
            sel[1] = 1'b1;
        end else if (region_hit[2]) begin
            sel[2] = 1'b1;
        end else if (region_hit[3]) begin
            sel[3] = 1'b1;
        end
    end

    assign no_match = (region_hit == 4'b0000);
    assign HSEL_S   = sel;
    assign active   = (HTRANS == TRANS_NONSEQ) || (HTRANS == TRANS_SEQ);

    // ---------------- data-phase state ----------------
    // dsel and haddr_dp only advance when the current data phase completes,
    // so a slave wait state holds both on the stalled transfer.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dsel     <= 5'(1 << DEFAULT_SLV);
            haddr_dp <= 32'h0000_0000;
        end else if (HREADY) begin
            dsel <= {no_match, sel};
            if (active) begin
                haddr_dp <= HADDR;
            end
        end
    end

    my_riscv_core_matrix_bus_default_slave u_default_slave (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .hsel      (no_match),
        .active    (active),
        .hready    (HREADY),
        .hreadyout (def_ready),
        .hresp     (def_resp)
    );

    // ---------------- response mux ----------------
    // Driven only by dsel and the slave returns; HSEL_S never sees these.
    always_comb begin
        HREADY = 1'b1;
        HRESP  = RESP_OKAY;
        HRDATA = 32'h0000_0000;
        if (dsel[DEFAULT_SLV]) begin
            HREADY = def_ready;
            HRESP  = def_resp;
        end
        for (int n = 0; n < NUM_SLAVES; n++) begin
            if (dsel[n]) begin
                HREADY = HREADYOUT_S[n];
                HRESP  = HRESP_S[2*n +: 2];
                HRDATA = HRDATA_S[32*n +: 32];
            end
        end
    end

    // ---------------- error capture ----------------
    // Capture on the first ERROR cycle (HREADY low). A clear in the same
    // cycle frees the register, so the new error is taken instead of lost.
    assign capture = (HRESP == RESP_ERROR) && !HREADY && (!err_valid || ERRCLR);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            err_valid <= 1'b0;
            err_addr  <= 32'h0000_0000;
            err_slv   <= 3'd0;
        end else if (capture) begin
            err_valid <= 1'b1;
            err_addr  <= haddr_dp;
            err_slv   <= onehot_to_index(dsel);
        end else if (ERRCLR) begin
            err_valid <= 1'b0;
        end
    end

    assign ERRVALID = err_valid;
    assign ERRADDR  = err_addr;
    assign ERRSLV   = err_slv;

endmodule

// File: tb/tb_my_riscv_core_matrix_bus_decoder.sv
module tb_my_riscv_core_matrix_bus_decoder;

    logic         HCLK = 1'b0;
    logic         HRESETn;
    logic [31:0]  HADDR;
    logic [1:0]   HTRANS;
    logic [3:0]   HSEL_S;
    logic [3:0]   HREADYOUT_S;
    logic [7:0]   HRESP_S;
    logic [127:0] HRDATA_S;
    logic         HREADY;
    logic [1:0]   HRESP;
    logic [31:0]  HRDATA;
    logic         ERRCLR;
    logic         ERRVALID;
    logic [31:0]  ERRADDR;
    logic [2:0]   ERRSLV;

    // second instance with overlapping slave 2/3 regions
    logic [3:0]   hsel2;
    logic         hready2;
    logic [1:0]   hresp2;
    logic [31:0]  hrdata2;
    logic         errvalid2;
    logic [31:0]  erraddr2;
    logic [2:0]   errslv2;

    int errors = 0;
    int checks = 0;

    logic [31:0] ref_base [4] = '{32'h0000_0000, 32'h2000_0000, 32'h4000_0000, 32'h6000_0000};
    logic [31:0] ref_mask [4] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hF000_0000, 32'hF000_0000};

    always #5 HCLK = ~HCLK;

    my_riscv_core_matrix_bus_decoder dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSEL_S(HSEL_S), .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S),
        .HRDATA_S(HRDATA_S), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
        .ERRCLR(ERRCLR), .ERRVALID(ERRVALID), .ERRADDR(ERRADDR), .ERRSLV(ERRSLV)
    );

    my_riscv_core_matrix_bus_decoder #(
        .BASE3(32'h4000_0000), .MASK3(32'hF000_0000)
    ) dut_overlap (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSEL_S(hsel2), .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S),
        .HRDATA_S(HRDATA_S), .HREADY(hready2), .HRESP(hresp2), .HRDATA(hrdata2),
        .ERRCLR(ERRCLR), .ERRVALID(errvalid2), .ERRADDR(erraddr2), .ERRSLV(errslv2)
    );

    // Address map rule: first region whose masked address equals its base.
    function automatic int ref_decode(input logic [31:0] a);
        for (int i = 0; i < 4; i++) begin
            if ((a & ref_mask[i]) == ref_base[i]) return i;
        end
        return 4;
    endfunction

    task automatic tick;
        @(posedge HCLK);
        #1;
    endtask

    task automatic test_reset;
        HRESETn = 1'b0;
        #3;
        checks++; if (HREADY !== 1'b1) begin errors++; $display("FAIL reset_hready got=%b exp=1", HREADY); end
        checks++; if (HRESP !== 2'b00) begin errors++; $display("FAIL reset_hresp got=%b exp=00", HRESP); end
        checks++; if (HRDATA !== 32'h0) begin errors++; $display("FAIL reset_hrdata got=%h exp=0", HRDATA); end
        checks++; if (ERRVALID !== 1'b0) begin errors++; $display("FAIL reset_errvalid got=%b exp=0", ERRVALID); end
        checks++; if (ERRADDR !== 32'h0) begin errors++; $display("FAIL reset_erraddr got=%h exp=0", ERRADDR); end
        checks++; if (ERRSLV !== 3'd0) begin errors++; $display("FAIL reset_errslv got=%0d exp=0", ERRSLV); end
        repeat (2) tick;
        HRESETn = 1'b1;
        tick;
        checks++; if (HREADY !== 1'b1 || HRESP !== 2'b00) begin errors++; $display("FAIL post_reset_idle got=%b/%b exp=1/00", HREADY, HRESP); end
    endtask

    task automatic test_slave1_read;
        HRDATA_S = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
        HADDR = 32'h2000_0010; HTRANS = 2'b10;
        #1;
        checks++; if (HSEL_S !== 4'b0010) begin errors++; $display("FAIL s1_hsel got=%b exp=0010", HSEL_S); end
        tick;
        HADDR = 32'h0; HTRANS = 2'b00;
        #1;
        checks++; if (HRDATA !== 32'hBBBB_0001) begin errors++; $display("FAIL s1_hrdata got=%h exp=bbbb0001", HRDATA); end
        checks++; if (HRESP !== 2'b00 || HREADY !== 1'b1) begin errors++; $display("FAIL s1_resp got=%b/%b exp=1/00", HREADY, HRESP); end
        tick;
    endtask

    task automatic test_default_error;
        HADDR = 32'h8000_0000; HTRANS = 2'b10;
        #1;
        checks++; if (HSEL_S !== 4'b0000) begin errors++; $display("FAIL def_hsel got=%b exp=0000", HSEL_S); end
        tick;
        HADDR = 32'h0; HTRANS = 2'b00;
        #1;
        checks++; if (HREADY !== 1'b0 || HRESP !== 2'b01) begin errors++; $display("FAIL def_err_c1 got=%b/%b exp=0/01", HREADY, HRESP); end
        tick;
        checks++; if (HREADY !== 1'b1 || HRESP !== 2'b01) begin errors++; $display("FAIL def_err_c2 got=%b/%b exp=1/01", HREADY, HRESP); end
        checks++; if (ERRVALID !== 1'b1) begin errors++; $display("FAIL def_errvalid got=%b exp=1", ERRVALID); end
        checks++; if (ERRADDR !== 32'h8000_0000) begin errors++; $display("FAIL def_erraddr got=%h exp=80000000", ERRADDR); end
        checks++; if (ERRSLV !== 3'd4) begin errors++; $display("FAIL def_errslv got=%0d exp=4", ERRSLV); end
        tick;
        checks++; if (HREADY !== 1'b1 || HRESP !== 2'b00) begin errors++; $display("FAIL def_after got=%b/%b exp=1/00", HREADY, HRESP); end
    endtask

    task automatic test_error_lock;
        HADDR = 32'h9000_0000; HTRANS = 2'b10;
        tick;
        HADDR = 32'h0; HTRANS = 2'b00;
        tick;
        checks++; if (ERRVALID !== 1'b1 || ERRADDR !== 32'h8000_0000) begin errors++; $display("FAIL lock_keep got=%b/%h exp=1/80000000", ERRVALID, ERRADDR); end
        // back-to-back new error from the last ERROR cycle
        HADDR = 32'hA000_0000; HTRANS = 2'b10;
        tick;
        HADDR = 32'h0; HTRANS = 2'b00; ERRCLR = 1'b1;
        #1;
        checks++; if (HREADY !== 1'b0 || HRESP !== 2'b01) begin errors++; $display("FAIL lock_c1 got=%b/%b exp=0/01", HREADY, HRESP); end
        tick;
        ERRCLR = 1'b0;
        checks++; if (ERRVALID !== 1'b1) begin errors++; $display("FAIL clr_capture_valid got=%b exp=1", ERRVALID); end
        checks++; if (ERRADDR !== 32'hA000_0000) begin errors++; $display("FAIL clr_capture_addr got=%h exp=a0000000", ERRADDR); end
        tick;
        ERRCLR = 1'b1;
        tick;
        ERRCLR = 1'b0;
        checks++; if (ERRVALID !== 1'b0) begin errors++; $display("FAIL clr_only got=%b exp=0", ERRVALID); end
        checks++; if (ERRADDR !== 32'hA000_0000) begin errors++; $display("FAIL clr_keeps_addr got=%h exp=a0000000", ERRADDR); end
    endtask

    task automatic test_wait_state;
        HRDATA_S = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0F0F};
        HADDR = 32'h4000_0004; HTRANS = 2'b10;
        #1;
        checks++; if (HSEL_S !== 4'b0100) begin errors++; $display("FAIL ws_hsel got=%b exp=0100", HSEL_S); end
        tick;
        HREADYOUT_S = 4'b1011; HADDR = 32'h0000_0100; HTRANS = 2'b10;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (HREADY !== 1'b0) begin errors++; $display("FAIL ws_wait%0d hready got=%b exp=0", i, HREADY); end
            checks++; if (HRDATA !== 32'h2222_2222) begin errors++; $display("FAIL ws_wait%0d hrdata got=%h exp=22222222", i, HRDATA); end
            checks++; if (HSEL_S !== 4'b0001) begin errors++; $display("FAIL ws_wait%0d hsel got=%b exp=0001", i, HSEL_S); end
            tick;
        end
        HREADYOUT_S = 4'hF;
        #1;
        checks++; if (HREADY !== 1'b1 || HRDATA !== 32'h2222_2222) begin errors++; $display("FAIL ws_release got=%b/%h exp=1/22222222", HREADY, HRDATA); end
        tick;
        HTRANS = 2'b00;
        #1;
        checks++; if (HRDATA !== 32'h0000_0F0F) begin errors++; $display("FAIL ws_next_slave got=%h exp=00000f0f", HRDATA); end
        tick;
    endtask

    task automatic test_reset_mid_error;
        HADDR = 32'h8000_0000; HTRANS = 2'b10;
        tick;
        HADDR = 32'h0; HTRANS = 2'b00;
        #1;
        checks++; if (HREADY !== 1'b0) begin errors++; $display("FAIL rme_c1 got=%b exp=0", HREADY); end
        HRESETn = 1'b0;
        #1;
        checks++; if (HREADY !== 1'b1 || HRESP !== 2'b00 || ERRVALID !== 1'b0) begin errors++; $display("FAIL rme_async got=%b/%b/%b exp=1/00/0", HREADY, HRESP, ERRVALID); end
        tick;
        HRESETn = 1'b1;
        tick;
        checks++; if (HREADY !== 1'b1 || HRESP !== 2'b00) begin errors++; $display("FAIL rme_release got=%b/%b exp=1/00", HREADY, HRESP); end
    endtask

    task automatic test_overlap;
        HADDR = 32'h4000_0000; HTRANS = 2'b00;
        #1;
        checks++; if (hsel2 !== 4'b0100) begin errors++; $display("FAIL ovl_hsel got=%b exp=0100", hsel2); end
        HADDR = 32'h4FFF_FFFC;
        #1;
        checks++; if (hsel2 !== 4'b0100) begin errors++; $display("FAIL ovl_hsel_top got=%b exp=0100", hsel2); end
        HADDR = 32'h6000_0010;
        #1;
        checks++; if (hsel2 !== 4'b0000) begin errors++; $display("FAIL ovl_hsel_miss got=%b exp=0000", hsel2); end
        tick;
    endtask

    task automatic test_random;
        int tgt, err_left, dec, es;
        logic ev;
        logic [31:0] ea, adp, exp_rdata;
        logic exp_ready;
        logic [1:0] exp_resp;
        logic [3:0] exp_hsel;
        HTRANS = 2'b00; ERRCLR = 1'b0; HREADYOUT_S = 4'hF; HRESP_S = 8'h00;
        HRESETn = 1'b0;
        tick;
        HRESETn = 1'b1;
        tgt = 4; err_left = 0; ev = 1'b0; ea = 32'h0; adp = 32'h0; es = 0;
        for (int c = 0; c < 400; c++) begin
            case ($urandom_range(0, 5))
                0: HADDR = 32'h0000_0000 | 32'($urandom_range(0, 16'hFFFF));
                1: HADDR = 32'h2000_0000 | 32'($urandom_range(0, 16'hFFFF));
                2: HADDR = 32'h4000_0000 | ($urandom & 32'h0FFF_FFFF);
                3: HADDR = 32'h6000_0000 | ($urandom & 32'h0FFF_FFFF);
                default: HADDR = $urandom;
            endcase
            HTRANS = 2'($urandom_range(0, 3));
            for (int n = 0; n < 4; n++) begin
                HREADYOUT_S[n] = ($urandom_range(0, 3) != 0);
                HRESP_S[2*n +: 2] = ($urandom_range(0, 5) == 0) ? 2'b01 : 2'b00;
            end
            HRDATA_S = {$urandom, $urandom, $urandom, $urandom};
            ERRCLR = ($urandom_range(0, 7) == 0);
            #1;
            dec = ref_decode(HADDR);
            exp_hsel = (dec < 4) ? 4'(1 << dec) : 4'b0000;
            if (tgt < 4) begin
                exp_ready = HREADYOUT_S[tgt];
                exp_resp  = HRESP_S[2*tgt +: 2];
                exp_rdata = HRDATA_S[32*tgt +: 32];
            end else begin
                exp_ready = (err_left != 2);
                exp_resp  = (err_left != 0) ? 2'b01 : 2'b00;
                exp_rdata = 32'h0;
            end
            checks++; if (HSEL_S !== exp_hsel) begin errors++; $display("FAIL rnd%0d hsel got=%b exp=%b", c, HSEL_S, exp_hsel); end
            checks++; if (HREADY !== exp_ready) begin errors++; $display("FAIL rnd%0d hready got=%b exp=%b", c, HREADY, exp_ready); end
            checks++; if (HRESP !== exp_resp) begin errors++; $display("FAIL rnd%0d hresp got=%b exp=%b", c, HRESP, exp_resp); end
            checks++; if (HRDATA !== exp_rdata) begin errors++; $display("FAIL rnd%0d hrdata got=%h exp=%h", c, HRDATA, exp_rdata); end
            checks++; if (ERRVALID !== ev) begin errors++; $display("FAIL rnd%0d errvalid got=%b exp=%b", c, ERRVALID, ev); end
            if (ev) begin
                checks++; if (ERRADDR !== ea || ERRSLV !== 3'(es)) begin errors++; $display("FAIL rnd%0d errinfo got=%h/%0d exp=%h/%0d", c, ERRADDR, ERRSLV, ea, es); end
            end
            // advance the reference by one clock
            if (exp_resp == 2'b01 && !exp_ready && (!ev || ERRCLR)) begin
                ev = 1'b1; ea = adp; es = tgt;
            end else if (ERRCLR) begin
                ev = 1'b0;
            end
            if (exp_ready) begin
                if (HTRANS[1]) adp = HADDR;
                tgt = dec;
                err_left = (dec == 4 && HTRANS[1]) ? 2 : 0;
            end else if (err_left > 0) begin
                err_left--;
            end
            tick;
        end
        ERRCLR = 1'b0; HTRANS = 2'b00;
    endtask

    initial begin
        HRESETn = 1'b0;
        HADDR = 32'h0; HTRANS = 2'b00; ERRCLR = 1'b0;
        HREADYOUT_S = 4'hF; HRESP_S = 8'h00; HRDATA_S = '0;
        test_reset;
        test_slave1_read;
        test_default_error;
        test_error_lock;
        test_wait_state;
        test_reset_mid_error;
        test_overlap;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/my_riscv_core_matrix_bus_decoder.md
MY_RISCV_CORE_MATRIX_BUS_DECODER -- requirements
Module: my_riscv_core_matrix_bus_decoder

Interface
REQ-001 Parameters (name, default, meaning), SHALL be:
- BASE0 0x0000_0000, MASK0 0xFFFF_0000: slave 0 region.
- BASE1 0x2000_0000, MASK1 0xFFFF_0000: slave 1 region.
- BASE2 0x4000_0000, MASK2 0xF000_0000: slave 2 region.
- BASE3 0x6000_0000, MASK3 0xF000_0000: slave 3 region.
REQ-002 Ports (name, direction, width, meaning), SHALL be:
- HCLK in 1: clock. HRESETn in 1: reset, asynchronous, active-low.
- HADDR in 32: master address. HTRANS in 2: master transfer type.
- HSEL_S out 4: per-slave select, bit n = slave n.
- HREADYOUT_S in 4: per-slave ready. HRESP_S in 8: slave n response at [2n+1:2n]. HRDATA_S in 128: slave n read data at [32n+31:32n].
- HREADY out 1: muxed ready, to master and all slaves. HRESP out 2: muxed response. HRDATA out 32: muxed read data.
- ERRCLR in 1: synchronous clear of error capture.
- ERRVALID out 1: error captured. ERRADDR out 32: captured address. ERRSLV out 3: captured target (0-3 slave, 4 default).

Function
REQ-003 Region n SHALL match when (HADDR & MASKn) == BASEn; lowest matching index wins; at most one HSEL_S bit set.
REQ-004 HSEL_S SHALL be combinational from HADDR only, independent of HTRANS.
REQ-005 When no region matches, the internal default slave SHALL be selected.
REQ-006 Data-phase select dsel (5-bit one-hot, bit 4 = default) SHALL load the address-phase decode on HCLK edges where HREADY=1; otherwise it holds.
REQ-007 HREADY, HRESP, HRDATA SHALL be muxed combinationally by dsel.
REQ-008 When dsel = default: HREADY/HRESP come from the default slave; HRDATA = 0.
REQ-009 Default slave, for a NONSEQ/SEQ transfer selected while HREADY=1, SHALL respond with a two-cycle ERROR:
- cycle 1: HREADY=0, HRESP=01;
- cycle 2: HREADY=1, HRESP=01.
IDLE/BUSY to default SHALL give zero-wait OKAY.
REQ-010 Address register haddr_dp SHALL load HADDR when HREADY=1 and HTRANS[1]=1.
REQ-011 Capture condition: HRESP=01 and HREADY=0 (first error cycle) and ERRVALID=0. On capture: ERRVALID<=1, ERRADDR<=haddr_dp, ERRSLV<=index of dsel.
REQ-012 Once ERRVALID=1, later errors SHALL NOT overwrite ERRADDR/ERRSLV until cleared.
REQ-013 ERRCLR=1 SHALL clear ERRVALID next edge. If ERRCLR and a capture condition occur in the same cycle, the capture SHALL win (ERRVALID stays 1, fields updated).
REQ-014 A slave wait state (HREADYOUT_S=0) SHALL freeze dsel and haddr_dp; the next address SHALL NOT be decoded into dsel until HREADY=1.
REQ-015 No combinational path SHALL exist from HRESP_S/HRDATA_S to HSEL_S.

Reset
REQ-016 Reset SHALL force:
- dsel = default (bit 4), haddr_dp = 0.
- ERRVALID = 0, ERRADDR = 0, ERRSLV = 0.
- Default slave: HREADY = 1, HRESP = 00, HRDATA = 0.
REQ-017 Reset asserted mid-transfer, including during an ERROR sequence, SHALL abort it; first cycle after release shows HREADY=1, HRESP=00.

Structure
REQ-018 HRESP encodings (OKAY 00, ERROR 01, RETRY 10, SPLIT 11) and the default-slave index (4) SHALL live in a shared matrix-bus package.
REQ-019 The default slave SHALL be one sub-module, my_riscv_core_matrix_bus_default_slave, instantiated with HSEL = no-match and HREADY = muxed HREADY.
REQ-020 Decode, dsel register, response mux and error capture SHALL reside in the top module.

Verification
REQ-021 HADDR=0x2000_0010, HTRANS=10, all slaves ready -> HSEL_S=0010; next cycle HRDATA = HRDATA_S[63:32], HRESP=00.
REQ-022 HADDR=0x8000_0000, HTRANS=10 -> HSEL_S=0000; next cycle HREADY=0, HRESP=01; following cycle HREADY=1, HRESP=01, ERRVALID=1, ERRADDR=0x8000_0000, ERRSLV=4.
REQ-023 HREADYOUT_S[2]=0 for 3 cycles after access to 0x4000_0004, with next address 0x0000_0100 presented -> HREADY=0 for 3 cycles, dsel stays slave 2, then moves to slave 0.
REQ-024 Second error at 0x9000_0000 while ERRVALID=1 -> ERRADDR stays 0x8000_0000. ERRCLR asserted on the first-error cycle of a new error -> ERRVALID stays 1, ERRADDR updated.
REQ-025 HRESETn asserted during cycle 1 of a default-slave ERROR -> outputs immediately HREADY=1, HRESP=00, ERRVALID=0.
REQ-026 Overlapping regions (BASE2=BASE3=0x4000_0000, same masks), access 0x4000_0000 -> HSEL_S=0100.
